// File: rtl/ram_pkg.sv
// Shared definitions for the cleared RAM: FSM state encodings and the
// lane-count log2 used to split byte addresses into word indices.
package ram_pkg;

  localparam logic [0:0] STATE_CLEAR = 1'b0;
  localparam logic [0:0] STATE_IDLE  = 1'b1;

  function automatic int unsigned log2_bytes(input int unsigned bytes);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < bytes) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ram_lane.sv
// One 8-bit byte lane of the RAM: single write port, registered read port,
// no reset on the array so it maps onto BlockRAM.
module ram_lane #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned IDX_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_en,
  input  logic [IDX_WIDTH-1:0] write_index,
  input  logic [7:0]           write_data,
  input  logic                 read_en,
  input  logic [IDX_WIDTH-1:0] read_index,
  output logic [7:0]           read_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[write_index] <= write_data;
    end
  end

  // Only the output register is reset; it holds between reads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      read_data <= '0;
    end else if (read_en) begin
      read_data <= mem[read_index];
    end
  end

endmodule

// File: rtl/ram_cleared.sv
// Byte-masked RAM with registered reads and a hardware clear engine.
// state | meaning
// CLEAR | sweeping zeros into every word, busy=1, requests ignored
// IDLE  | serving read/write requests, clear pulse starts a sweep
module ram_cleared
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    write_enable,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] write_mask,
  input  logic                    clear,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid,
  output logic                    busy,
  output logic [DATA_WIDTH/8-1:0] debug
);

  localparam int unsigned BYTES     = DATA_WIDTH / 8;
  localparam int unsigned LOG2B     = log2_bytes(BYTES);
  localparam int unsigned IDX_WIDTH = ADDR_WIDTH - LOG2B;
  localparam int unsigned DEPTH     = 1 << IDX_WIDTH;

  logic [0:0]           state;
  logic [IDX_WIDTH-1:0] clear_count;
  logic [IDX_WIDTH-1:0] word_index;
  logic [IDX_WIDTH-1:0] lane_index;
  logic                 clearing;
  logic                 take_request;
  logic                 accept_write;
  logic                 accept_read;

  assign busy        = (state == STATE_CLEAR);
  assign word_index  = address[ADDR_WIDTH-1:LOG2B];
  assign clearing    = reset & busy;
  // A clear pulse in IDLE wins over any request presented with it.
  assign take_request = reset & (state == STATE_IDLE) & ~clear;
  assign accept_write = take_request & enable & write_enable;
  assign accept_read  = take_request & enable & ~write_enable;
  assign lane_index   = clearing ? clear_count : word_index;

  generate
    if (LOG2B > 0) begin : g_unused_addr
      logic unused_addr_bits;
      assign unused_addr_bits = ^address[LOG2B-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= (CLEAR_ON_RESET != 1'b0) ? STATE_CLEAR : STATE_IDLE;
      clear_count <= '0;
      data_valid  <= 1'b0;
      debug       <= '0;
    end else begin
      data_valid <= accept_read;
      if (accept_write) begin
        debug <= write_mask;
      end
      case (state)
        STATE_CLEAR: begin
          if (clear_count == '1) begin
            state       <= STATE_IDLE;
            clear_count <= '0;
          end else begin
            clear_count <= clear_count + 1'b1;
          end
        end
        STATE_IDLE: begin
          if (clear) begin
            state <= STATE_CLEAR;
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < BYTES; i++) begin : g_lane
      logic       lane_we;
      logic [7:0] lane_wdata;

      assign lane_we    = clearing | (accept_write & ~write_mask[i]);
      assign lane_wdata = clearing ? 8'h00 : data_in[8*i +: 8];

      ram_lane #(
        .DEPTH     (DEPTH),
        .IDX_WIDTH (IDX_WIDTH)
      ) u_lane (
        .clk         (clk),
        .reset       (reset),
        .write_en    (lane_we),
        .write_index (lane_index),
        .write_data  (lane_wdata),
        .read_en     (accept_read),
        .read_index  (lane_index),
        .read_data   (data_out[8*i +: 8])
      );
    end
  endgenerate

endmodule

// File: tb/tb_ram_cleared.sv
// Self-checking bench for ram_cleared: a word-level reference model checked
// every cycle, plus directed literal expectations.
module tb_ram_cleared;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int BY    = 4;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, reset0, enable, write_enable, clear;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic [BY-1:0] write_mask;
  logic [DW-1:0] data_out, data_out0;
  logic          data_valid, data_valid0, busy, busy0;
  logic [BY-1:0] debug, debug0;

  ram_cleared #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .write_enable(write_enable),
    .address(address), .data_in(data_in), .write_mask(write_mask), .clear(clear),
    .data_out(data_out), .data_valid(data_valid), .busy(busy), .debug(debug));

  ram_cleared #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b0)) dut0 (
    .clk(clk), .reset(reset0), .enable(enable), .write_enable(write_enable),
    .address(address), .data_in(data_in), .write_mask(write_mask), .clear(clear),
    .data_out(data_out0), .data_valid(data_valid0), .busy(busy0), .debug(debug0));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: word array plus remaining sweep length.
  logic [31:0] mem_m [DEPTH];
  bit          known_m [DEPTH];
  int          clear_left = 0;
  bit          m_dv = 1'b0;
  logic [31:0] m_dout = '0;
  bit          m_dout_known = 1'b0;
  logic [3:0]  m_dbg = '0;
  bit          model_on = 1'b0;

  always @(posedge clk) begin : model
    int w;
    w = int'(address) / BY;
    if (!reset) begin
      clear_left   = DEPTH;
      m_dv         = 1'b0;
      m_dout       = '0;
      m_dout_known = 1'b1;
      m_dbg        = '0;
      model_on     = 1'b1;
    end else if (clear_left > 0) begin
      mem_m[DEPTH - clear_left]   = '0;
      known_m[DEPTH - clear_left] = 1'b1;
      clear_left--;
      m_dv = 1'b0;
    end else if (clear) begin
      clear_left = DEPTH;
      m_dv = 1'b0;
    end else if (enable && write_enable) begin
      for (int b = 0; b < BY; b++)
        if (!write_mask[b]) mem_m[w][8*b +: 8] = data_in[8*b +: 8];
      if (write_mask == '0) known_m[w] = 1'b1;
      m_dbg = write_mask;
      m_dv  = 1'b0;
    end else if (enable) begin
      m_dout       = mem_m[w];
      m_dout_known = known_m[w];
      m_dv         = 1'b1;
    end else begin
      m_dv = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("model_busy", busy, clear_left > 0);
      check("model_data_valid", data_valid, m_dv);
      check("model_debug", debug, m_dbg);
      if (m_dout_known) check("model_data_out", data_out, m_dout);
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
    enable = 1'b1; write_enable = 1'b1; address = a; data_in = d; write_mask = m;
    @(negedge clk);
    enable = 1'b0; write_enable = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [31:0] d, output logic v);
    enable = 1'b1; write_enable = 1'b0; address = a;
    @(negedge clk);
    enable = 1'b0;
    d = data_out;
    v = data_valid;
  endtask

  // Called at a negedge; counts cycles with busy high, optionally poking enable.
  task automatic count_busy(input bit poke, output int n, output bit dv_seen);
    n = 0;
    dv_seen = 1'b0;
    while (busy === 1'b1 && n < 1000) begin
      enable = poke & n[0];
      write_enable = 1'b0;
      n++;
      @(negedge clk);
      if (data_valid !== 1'b0) dv_seen = 1'b1;
    end
    enable = 1'b0;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic        v;
    int          n;
    bit          dvs;
    logic [31:0] rd_data [3];
    logic        rd_v [3];

    reset = 1'b0; reset0 = 1'b0; enable = 1'b0; write_enable = 1'b0; clear = 1'b0;
    address = '0; data_in = '0; write_mask = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b1);
    check("reset_data_out", data_out, 32'h0);
    check("reset_debug", debug, 4'h0);
    reset = 1'b1; reset0 = 1'b1;
    check("cor0_busy_after_reset", busy0, 1'b0);
    count_busy(1'b0, n, dvs);
    check("power_up_busy_cycles", n, 256);

    rd(10'h3FC, d, v);
    check("read_3fc_data", d, 32'h0);
    check("read_3fc_valid", v, 1'b1);

    wr(10'h010, 32'hDEADBEEF, 4'b0000);
    rd(10'h010, d, v);
    check("wr_rd_data", d, 32'hDEADBEEF);
    check("wr_rd_valid", v, 1'b1);
    check("wr_debug", debug, 4'b0000);
    @(negedge clk);
    check("valid_single_pulse", data_valid, 1'b0);
    check("data_out_holds", data_out, 32'hDEADBEEF);

    wr(10'h010, 32'h11223344, 4'b1010);
    rd(10'h013, d, v);
    check("masked_write_data", d, 32'hDE22BE44);
    check("masked_write_debug", debug, 4'b1010);

    wr(10'h000, 32'h01020304, 4'b0000);
    wr(10'h004, 32'hA5A5A5A5, 4'b0000);
    wr(10'h008, 32'h0BADF00D, 4'b1111);
    check("all_ones_mask_debug", debug, 4'b1111);
    wr(10'h008, 32'h0BADF00D, 4'b0000);
    enable = 1'b1; write_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      address = 10'(i * 4);
      @(negedge clk);
      rd_data[i] = data_out;
      rd_v[i]    = data_valid;
    end
    enable = 1'b0;
    check("b2b_data0", rd_data[0], 32'h01020304);
    check("b2b_data1", rd_data[1], 32'hA5A5A5A5);
    check("b2b_data2", rd_data[2], 32'h0BADF00D);
    check("b2b_valid", {rd_v[0], rd_v[1], rd_v[2]}, 3'b111);

    clear = 1'b1; enable = 1'b1; write_enable = 1'b1;
    address = 10'h020; data_in = 32'hFFFFFFFF; write_mask = 4'b0001;
    @(negedge clk);
    clear = 1'b0; enable = 1'b0; write_enable = 1'b0;
    count_busy(1'b1, n, dvs);
    check("clear_busy_cycles", n, 256);
    check("no_valid_while_busy", dvs, 1'b0);
    check("dropped_write_debug", debug, 4'b0000);
    rd(10'h010, d, v);
    check("cleared_010", d, 32'h0);
    rd(10'h020, d, v);
    check("cleared_020", d, 32'h0);

    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (50) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (49) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    count_busy(1'b0, n, dvs);
    check("reset_mid_clear_busy_cycles", n, 256);

    wr(10'h040, 32'hCAFEF00D, 4'b0000);
    reset0 = 1'b0;
    @(negedge clk);
    check("cor0_reset_busy", busy0, 1'b0);
    check("cor0_reset_data_out", data_out0, 32'h0);
    reset0 = 1'b1;
    enable = 1'b1; write_enable = 1'b0; address = 10'h040;
    @(negedge clk);
    enable = 1'b0;
    check("cor0_busy_after_release", busy0, 1'b0);
    check("cor0_retained_data", data_out0, 32'hCAFEF00D);
    check("cor0_retained_valid", data_valid0, 1'b1);
    check("main_read_040", data_out, 32'hCAFEF00D);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_cleared.md
Name: ram_cleared

Overview:
- Parametrised on-chip RAM for the soft core: byte-lane write masks, configurable data width and depth, registered reads.
- Adds a hardware clear engine that zeroes every word after reset or on request, plus busy/data_valid handshaking.
- Sits between the CPU memory controller and inferred iCE40 BlockRAM. Replaces the fixed 1 KiB, 32-bit data RAM.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; a multiple of 8. BYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 10, byte-address width. Word depth = 2**(ADDR_WIDTH - log2(BYTES)).
- CLEAR_ON_RESET, 1, 1 = run the clear engine when reset releases; 0 = go straight to IDLE.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  request strobe; sampled only when busy=0.
- write_enable  input  1  1 = write request, 0 = read request.
- address  input  ADDR_WIDTH  byte address; the low log2(BYTES) bits are ignored.
- data_in  input  DATA_WIDTH  write data.
- write_mask  input  BYTES  active-low byte-lane enables (0 = write that lane).
- clear  input  1  1-cycle pulse; starts a full clear from IDLE.
- data_out  output  DATA_WIDTH  registered read data.
- data_valid  output  1  1-cycle pulse, data_out holds the result of a read.
- busy  output  1  clear engine running; requests are ignored.
- debug  output  BYTES  write_mask of the last accepted write.

Behaviour:
- Reset (reset=0 at a rising edge):
  - data_out=0, data_valid=0, debug=0, clear counter=0.
  - State = CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - busy = 1 exactly when state is CLEAR, so it is 1 during reset when CLEAR_ON_RESET=1.
- Word index = address[ADDR_WIDTH-1 : log2(BYTES)]. No out-of-range case exists.
- State CLEAR:
  - Each cycle, write all-zero to word clear_count with all lanes enabled, then increment clear_count.
  - After the write to word DEPTH-1: go to IDLE and reset clear_count to 0.
  - The sweep takes DEPTH cycles; busy deasserts on the cycle after the last word is written.
- State IDLE, enable=1, write_enable=1:
  - At this edge, lanes with write_mask[i]=0 take data_in[8i+7:8i]; other lanes are unchanged.
  - debug <= write_mask. data_valid stays 0 and data_out holds its value.
  - A write with an all-ones mask is accepted but changes no storage; debug still updates.
- State IDLE, enable=1, write_enable=0:
  - data_out <= word, data_valid=1 in the following cycle. Read latency is 1.
  - Back-to-back reads every cycle are allowed; data_valid stays high continuously.
- Write at cycle N, read of the same word at N+1: returns the newly written data.
- Idle cycles (enable=0): data_valid=0, data_out holds.
- clear=1 in IDLE:
  - Enter CLEAR next cycle; it takes priority over a simultaneous enable, whose request is dropped.
  - clear=1 while already in CLEAR is ignored; the sweep continues and does not restart.
- enable while busy=1: ignored. No storage change, no data_valid, no debug update.
- Reset mid-clear: clear_count returns to 0. With CLEAR_ON_RESET=1 the sweep restarts from word 0.
- Storage is not reset except by the clear engine.
- Memory arrays must stay BlockRAM-inferable:
  - One write port and one read port per byte lane, with a registered read.
  - No asynchronous read and no reset on the storage arrays.

Decomposition:
- Shared package ram_pkg holds:
  - state encodings STATE_CLEAR and STATE_IDLE;
  - the function computing log2(BYTES).
- One natural sub-module, ram_lane: a single 8-bit-wide, DEPTH-deep byte lane with write enable and registered read.
- It is instantiated BYTES times via generate. The top holds the FSM, clear counter and handshake outputs.

Test Plan:
- Reset release, defaults (DATA_WIDTH=32, ADDR_WIDTH=10) -> busy=1 for exactly 256 cycles, then 0; a read of address 0x3FC returns 0x00000000 with data_valid one cycle later.
- Write 0xDEADBEEF to 0x010 with mask 4'b0000, then read 0x010 on the next cycle -> data_out=0xDEADBEEF, data_valid pulses once, debug=4'b0000.
- Write 0x11223344 with mask 4'b1010 over 0xDEADBEEF at 0x010, then read 0x013 -> data_out=0xDE22BE44 (low address bits ignored).
- Reads of 0x000, 0x004, 0x008 on consecutive cycles -> data_valid high for 3 cycles, data in order.
- clear pulse in IDLE with a simultaneous enable write to 0x020 -> the write is dropped and busy=1 for 256 cycles; then 0x010 and 0x020 read 0; enable pulses during busy produce no data_valid.
- reset asserted at clear cycle 100, released -> busy=1 for a full 256 cycles again; with CLEAR_ON_RESET=0, busy stays 0 and a prior nonzero word is retained.
